snake_cell: RTL and testbench

SNAKE_CELL -- requirements
Module: snake_cell

---
 rtl/snake_cell.sv | 93 +++++++++
 tb/tb_snake_cell.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_cell.sv
// snake_cell: one playfield cell tracking how long each snake's body stays lit here and sticky head collisions
module snake_cell #(
    parameter int COORD_W    = 5,
    parameter int LEN_W      = 16,
    parameter int NUM_SNAKES = 2,
    parameter int START_I    = 10,
    parameter int START_J    = 7,
    parameter int START_LEN  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sys,
    input  logic                          gameOver,
    input  logic [COORD_W-1:0]            i,
    input  logic [COORD_W-1:0]            j,
    input  logic [NUM_SNAKES*COORD_W-1:0] head_i,
    input  logic [NUM_SNAKES*COORD_W-1:0] head_j,
    input  logic [NUM_SNAKES-1:0]         head_valid,
    input  logic [NUM_SNAKES*LEN_W-1:0]   length,
    output logic [NUM_SNAKES-1:0]         occupied,
    output logic                          lightOn,
    output logic                          collide,
    output logic [NUM_SNAKES-1:0]         collide_mask
);
    typedef enum logic {OFF, ON} state_t;

    state_t               state     [NUM_SNAKES];
    state_t               state_nxt [NUM_SNAKES];
    logic [LEN_W-1:0]     cnt       [NUM_SNAKES];
    logic [LEN_W-1:0]     cnt_nxt   [NUM_SNAKES];
    logic [LEN_W-1:0]     rst_cnt   [NUM_SNAKES];
    logic [LEN_W:0]       len_eff   [NUM_SNAKES];
    logic [NUM_SNAKES-1:0] rst_on, hit, expiring, mask_nxt;
    logic [3:0]           nhits;
    logic                 blocking, coll_nxt;

    // Initial snake bodies: snake k lies on row START_I+2k, its head at START_J, older segments to the left
    for (genvar k = 0; k < NUM_SNAKES; k++) begin : g_rst
        localparam int ROW = START_I + 2 * k;
        assign rst_on[k]  = (int'(i) == ROW) && (int'(j) >= START_J - START_LEN + 1) && (int'(j) <= START_J);
        assign rst_cnt[k] = rst_on[k] ? LEN_W'(START_J - int'(j)) : '0;
    end

    // Next-state: age each body segment, detect expiry, heads and collisions for this tick
    always_comb begin
        hit      = '0;
        expiring = '0;
        blocking = 1'b0;
        nhits    = '0;
        coll_nxt = collide;
        mask_nxt = collide_mask;
        for (int k = 0; k < NUM_SNAKES; k++) begin
            len_eff[k]  = (length[k*LEN_W +: LEN_W] == '0) ? (LEN_W+1)'(1) : {1'b0, length[k*LEN_W +: LEN_W]};
            hit[k]      = head_valid[k] && head_i[k*COORD_W +: COORD_W] == i && head_j[k*COORD_W +: COORD_W] == j;
            expiring[k] = state[k] == ON && ({1'b0, cnt[k]} + 1'b1 >= len_eff[k]);
            blocking    = blocking | (state[k] == ON && !expiring[k]);
            nhits       = nhits + {3'b0, hit[k]};
        end
        for (int k = 0; k < NUM_SNAKES; k++) begin
            state_nxt[k] = state[k] == OFF ? (hit[k] ? ON : OFF) : (expiring[k] ? OFF : ON);
            cnt_nxt[k]   = (state[k] == OFF || expiring[k] || hit[k]) ? '0 : cnt[k] + 1'b1;
            if (hit[k] && (blocking || nhits > 4'd1)) begin
                mask_nxt[k] = 1'b1;
                coll_nxt    = 1'b1;
            end
        end
    end

    // State register: reset loads the starting body, otherwise advance only on live game ticks
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SNAKES; k++) begin
                state[k] <= rst_on[k] ? ON : OFF;
                cnt[k]   <= rst_cnt[k];
            end
            collide      <= 1'b0;
            collide_mask <= '0;
        end else if (sys && !gameOver) begin
            for (int k = 0; k < NUM_SNAKES; k++) begin
                state[k] <= state_nxt[k];
                cnt[k]   <= cnt_nxt[k];
            end
            collide      <= coll_nxt;
            collide_mask <= mask_nxt;
        end
    end

    // Outputs taken straight from the state registers; the light is blanked on game over
    always_comb begin
        for (int k = 0; k < NUM_SNAKES; k++) occupied[k] = state[k] == ON;
        lightOn = |occupied && !gameOver;
    end
endmodule

// File: tb/tb_snake_cell.sv
// tb_snake_cell: directed and randomized checks of snake_cell against a behavioural model
module tb_snake_cell;
    localparam int CW = 5, LW = 16, N = 2, SI = 10, SJ = 7, SL = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0, sys = 1'b0, gameOver = 1'b0;
    logic [CW-1:0]   i = 5'd10, j = 5'd5;
    logic [N*CW-1:0] head_i = '0, head_j = '0;
    logic [N-1:0]    head_valid = '0;
    logic [N*LW-1:0] length = {16'd3, 16'd3};
    logic [N-1:0]    occupied, collide_mask;
    logic            lightOn, collide;

    int compared = 0, mismatched = 0;

    snake_cell #(.COORD_W(CW), .LEN_W(LW), .NUM_SNAKES(N), .START_I(SI), .START_J(SJ), .START_LEN(SL)) dut (
        .clk(clk), .reset(reset), .sys(sys), .gameOver(gameOver), .i(i), .j(j),
        .head_i(head_i), .head_j(head_j), .head_valid(head_valid), .length(length),
        .occupied(occupied), .lightOn(lightOn), .collide(collide), .collide_mask(collide_mask));

    always #5 clk = ~clk;

    // Behavioural model: per snake "lit" flag and age in ticks
    logic [N-1:0] m_on = '0, m_mask = '0;
    int           m_age [N];
    logic         m_coll = 1'b0, mvalid = 1'b0;

    always @(posedge clk) begin : model
        int  len, nh;
        bit  blk;
        bit  h [N];
        bit  ex [N];
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                bit on;
                on = (int'(i) == SI + 2 * k) && (int'(j) >= SJ - SL + 1) && (int'(j) <= SJ);
                m_on[k]  <= on;
                m_age[k] <= on ? SJ - int'(j) : 0;
            end
            m_coll <= 1'b0;
            m_mask <= '0;
            mvalid <= 1'b1;
        end else if (sys && !gameOver) begin
            nh  = 0;
            blk = 0;
            for (int k = 0; k < N; k++) begin
                len   = int'(length[k*LW +: LW]);
                if (len == 0) len = 1;
                h[k]  = head_valid[k] && head_i[k*CW +: CW] == i && head_j[k*CW +: CW] == j;
                ex[k] = m_on[k] && (m_age[k] + 1 >= len);
                if (m_on[k] && !ex[k]) blk = 1;
                if (h[k]) nh++;
            end
            for (int k = 0; k < N; k++) begin
                if (!m_on[k]) begin
                    m_on[k]  <= h[k];
                    m_age[k] <= 0;
                end else if (ex[k]) begin
                    m_on[k]  <= 1'b0;
                    m_age[k] <= 0;
                end else begin
                    m_age[k] <= h[k] ? 0 : m_age[k] + 1;
                end
                if (h[k] && (blk || nh > 1)) begin
                    m_mask[k] <= 1'b1;
                    m_coll    <= 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (mvalid) begin
            compared++;
            if (occupied !== m_on || collide !== m_coll || collide_mask !== m_mask || lightOn !== (|m_on && !gameOver)) begin
                mismatched++;
                $display("FAIL cycle t=%0t occ=%b/%b coll=%b/%b mask=%b/%b light=%b/%b", $time,
                         occupied, m_on, collide, m_coll, collide_mask, m_mask, lightOn, |m_on && !gameOver);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit g, input bit r);
        #1;
        sys = s;
        gameOver = g;
        reset = r;
        @(negedge clk);
    endtask

    task automatic heads(input logic [1:0] v, input int i0, input int j0, input int i1, input int j1);
        #1;
        head_valid = v;
        head_i = {CW'(i1), CW'(i0)};
        head_j = {CW'(j1), CW'(j0)};
    endtask

    initial begin
        @(negedge clk);
        // Default reset at cell (10,5): snake 0 tail with age 2
        i = 5'd10; j = 5'd5;
        cyc(0, 0, 0);
        chk("r35_reset_occ", {30'b0, occupied}, 32'd1);
        chk("r35_model_occ", {30'b0, m_on}, 32'd1);
        chk("r35_reset_coll", {29'b0, collide, collide_mask}, 32'd0);
        cyc(1, 0, 1);
        chk("r35_first_tick", {30'b0, occupied}, 32'd0);
        // Tail expiring while snake 1 head enters: no collision
        cyc(0, 0, 0);
        heads(2'b10, 0, 0, 10, 5);
        cyc(1, 0, 1);
        chk("r39_occ", {30'b0, occupied}, 32'd2);
        chk("r39_coll", {29'b0, collide, collide_mask}, 32'd0);
        // Two heads enter an empty cell together
        i = 5'd3; j = 5'd3;
        heads(2'b00, 0, 0, 0, 0);
        cyc(0, 0, 0);
        heads(2'b11, 3, 3, 3, 3);
        cyc(1, 0, 1);
        chk("r38_occ", {30'b0, occupied}, 32'd3);
        chk("r38_coll", {29'b0, collide, collide_mask}, 32'd7);
        chk("r38_model", {29'b0, m_coll, m_mask}, 32'd7);
        // Head 0 enters with length 3: lit for exactly 3 ticks
        heads(2'b00, 0, 0, 0, 0);
        cyc(0, 0, 0);
        heads(2'b01, 3, 3, 0, 0);
        cyc(1, 0, 1);
        heads(2'b00, 0, 0, 0, 0);
        chk("r36_t0", {30'b0, occupied}, 32'd1);
        cyc(1, 0, 1);
        chk("r36_t1", {30'b0, occupied}, 32'd1);
        cyc(1, 0, 1);
        chk("r36_t2", {30'b0, occupied}, 32'd1);
        cyc(1, 0, 1);
        chk("r36_t3", {30'b0, occupied}, 32'd0);
        chk("r36_coll", {31'b0, collide}, 32'd0);
        // Head 1 enters snake 0's fresh body: sticky collision
        length = {16'd3, 16'd4};
        cyc(0, 0, 0);
        heads(2'b01, 3, 3, 0, 0);
        cyc(1, 0, 1);
        heads(2'b10, 0, 0, 3, 3);
        cyc(1, 0, 1);
        heads(2'b00, 0, 0, 0, 0);
        chk("r37_coll", {29'b0, collide, collide_mask}, 32'd6);
        for (int t = 0; t < 6; t++) cyc(1, 0, 1);
        chk("r37_sticky", {29'b0, collide, collide_mask}, 32'd6);
        // Game over freezes a lit cell and blanks the light
        length = {16'd3, 16'd3};
        i = 5'd10; j = 5'd7;
        cyc(0, 0, 0);
        for (int t = 0; t < 5; t++) begin
            cyc(1, 1, 1);
            chk("r40_dark", {31'b0, lightOn}, 32'd0);
            chk("r40_hold", {30'b0, occupied}, 32'd1);
        end
        cyc(1, 0, 1);
        chk("r40_resume1", {31'b0, lightOn}, 32'd1);
        cyc(1, 0, 1);
        chk("r40_resume2", {30'b0, occupied}, 32'd1);
        cyc(1, 1, 0);
        chk("r40_reset_mid", {30'b0, occupied}, 32'd1);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        chk("r40_expire", {30'b0, occupied}, 32'd0);
        // Randomized play
        for (int t = 0; t < 4000; t++) begin
            logic [N-1:0] v;
            int hi [N];
            int hj [N];
            if ($urandom_range(0, 99) < 2) begin
                case ($urandom_range(0, 3))
                    0: begin i = 5'd10; j = 5'($urandom_range(3, 8)); end
                    1: begin i = 5'd12; j = 5'($urandom_range(4, 7)); end
                    default: begin i = 5'($urandom_range(0, 31)); j = 5'($urandom_range(0, 31)); end
                endcase
            end
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    hi[k] = int'(i); hj[k] = int'(j);
                end else begin
                    hi[k] = $urandom_range(0, 31); hj[k] = $urandom_range(0, 31);
                end
                if ($urandom_range(0, 9) == 0) length[k*LW +: LW] = LW'($urandom_range(0, 6));
            end
            v = 2'($urandom_range(0, 3));
            heads(v, hi[0], hj[0], hi[1], hj[1]);
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 99) >= 3);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
